// File: rtl/forward_ctrl_pkg.sv
// Shared constants and types for the LEGv8 EX-stage forwarding controller.
package forward_ctrl_pkg;

   localparam int REG_BITS = 5;
   localparam int ZERO_REG = 31;

   // Operand-mux select codes; 2'b11 is never produced.
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,   // register-file value
      FWD_WB  = 2'b01,   // MEM/WB writeback data
      FWD_MEM = 2'b10    // EX/MEM ALU result
   } fwd_sel_t;

endpackage

// File: rtl/forward_ctrl_stage_reg.sv
// One pipeline-stage destination record {valid, rd, regwrite, memread}.
// A synchronous bubble turns the stage into an empty slot.
module fwd_stage_reg #(
   parameter int REG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                bubble,
   input  logic                valid_nxt,
   input  logic [REG_BITS-1:0] rd_nxt,
   input  logic                regwrite_nxt,
   input  logic                memread_nxt,
   output logic                valid,
   output logic [REG_BITS-1:0] rd,
   output logic                regwrite,
   output logic                memread
);

   // Advance the record one stage per clock, or insert an empty slot.
   // NOTE: every field is reset, not just valid, so a freshly reset stage
   // can never present stale metadata to the match logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         rd       <= '0;
         regwrite <= 1'b0;
         memread  <= 1'b0;
      end else if (bubble) begin
         valid    <= 1'b0;
         rd       <= '0;
         regwrite <= 1'b0;
         memread  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all stage registers sampling
         // pre-edge values, so EX->MEM->WB shifts without races.
         valid    <= valid_nxt;
         rd       <= rd_nxt;
         regwrite <= regwrite_nxt;
         memread  <= memread_nxt;
      end
   end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage LEGv8 pipeline.
// Produces registered operand-mux selects for the EX stage and a
// combinational stall for PC and IF/ID.
module forward_ctrl #(
   parameter int REG_BITS = forward_ctrl_pkg::REG_BITS,
   parameter int ZERO_REG = forward_ctrl_pkg::ZERO_REG
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rn,
   input  logic [REG_BITS-1:0] id_rm,
   input  logic                id_uses_rn,
   input  logic                id_uses_rm,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                flush,
   output logic [1:0]          fwd_a,
   output logic [1:0]          fwd_b,
   output logic                stall
);

   import forward_ctrl_pkg::*;

   logic                ex_valid,  mem_valid,  wb_valid;
   logic [REG_BITS-1:0] ex_rd,     mem_rd,     wb_rd;
   logic                ex_regwrite, mem_regwrite, wb_regwrite;
   logic                ex_memread,  mem_memread,  wb_memread;

   logic     ex_rn, ex_rm, mem_rn, mem_rm;
   logic     load_use;
   fwd_sel_t fwd_a_nxt, fwd_b_nxt;

   // A stage produces register r when it holds a real writer of r; XZR never counts.
   function automatic logic live(input logic                valid_s,
                                 input logic                regwrite_s,
                                 input logic [REG_BITS-1:0] rd_s,
                                 input logic [REG_BITS-1:0] r);
      return valid_s && regwrite_s && (rd_s == r) && (rd_s != REG_BITS'(ZERO_REG));
   endfunction

   // EX takes the ID instruction, or a bubble on stall/flush.
   fwd_stage_reg #(.REG_BITS(REG_BITS)) u_ex (
      .clk          (clk),
      .rst_n        (rst_n),
      .bubble       (stall | flush),
      .valid_nxt    (id_valid),
      .rd_nxt       (id_rd),
      .regwrite_nxt (id_regwrite),
      .memread_nxt  (id_memread),
      .valid        (ex_valid),
      .rd           (ex_rd),
      .regwrite     (ex_regwrite),
      .memread      (ex_memread)
   );

   // MEM takes EX; a flush kills the instruction leaving EX.
   fwd_stage_reg #(.REG_BITS(REG_BITS)) u_mem (
      .clk          (clk),
      .rst_n        (rst_n),
      .bubble       (flush),
      .valid_nxt    (ex_valid),
      .rd_nxt       (ex_rd),
      .regwrite_nxt (ex_regwrite),
      .memread_nxt  (ex_memread),
      .valid        (mem_valid),
      .rd           (mem_rd),
      .regwrite     (mem_regwrite),
      .memread      (mem_memread)
   );

   // WB is tracked for completeness; the register file bypasses it internally.
   fwd_stage_reg #(.REG_BITS(REG_BITS)) u_wb (
      .clk          (clk),
      .rst_n        (rst_n),
      .bubble       (1'b0),
      .valid_nxt    (mem_valid),
      .rd_nxt       (mem_rd),
      .regwrite_nxt (mem_regwrite),
      .memread_nxt  (mem_memread),
      .valid        (wb_valid),
      .rd           (wb_rd),
      .regwrite     (wb_regwrite),
      .memread      (wb_memread)
   );

   // Record fields that no forwarding decision looks at.
   logic unused_rec;
   assign unused_rec = ^{wb_valid, wb_rd, wb_regwrite, wb_memread, mem_memread};

   // Producer matches for each ID source operand.
   assign ex_rn  = id_uses_rn && live(ex_valid,  ex_regwrite,  ex_rd,  id_rn);
   assign ex_rm  = id_uses_rm && live(ex_valid,  ex_regwrite,  ex_rd,  id_rm);
   assign mem_rn = id_uses_rn && live(mem_valid, mem_regwrite, mem_rd, id_rn);
   assign mem_rm = id_uses_rm && live(mem_valid, mem_regwrite, mem_rd, id_rm);

   // A load in EX cannot feed the ID instruction in time; a flush wins.
   assign load_use = id_valid && ex_memread && (ex_rn || ex_rm);
   assign stall    = load_use && !flush;

   // Next-cycle selects: the newest producer wins, empty slots get FWD_REG.
   always_comb begin
      // NOTE: defaults first so every path assigns both selects and no latch is inferred.
      fwd_a_nxt = FWD_REG;
      fwd_b_nxt = FWD_REG;
      if (id_valid && !stall && !flush) begin
         if (ex_rn)       fwd_a_nxt = FWD_MEM;
         else if (mem_rn) fwd_a_nxt = FWD_WB;
         if (ex_rm)       fwd_b_nxt = FWD_MEM;
         else if (mem_rm) fwd_b_nxt = FWD_WB;
      end
   end

   // Hold the selects stable for the whole EX cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
      end else begin
         fwd_a <= fwd_a_nxt;
         fwd_b <= fwd_b_nxt;
      end
   end

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: expected selects are queued when an
// instruction is presented in ID and compared after the clock edge that
// registers them.
module tb_forward_ctrl;

   localparam logic [1:0] S_REG = 2'b00;
   localparam logic [1:0] S_WB  = 2'b01;
   localparam logic [1:0] S_MEM = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rn;
      logic [4:0] rm;
      logic       uses_rn;
      logic       uses_rm;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_memread, flush;
   logic [4:0] id_rn, id_rm, id_rd;
   logic [1:0] fwd_a, fwd_b;
   logic       stall;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [3:0] exp_q[$];
   string      name_q[$];
   logic [3:0] mon_exp;
   string      mon_name;

   forward_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rn       (id_rn),
      .id_rm       (id_rm),
      .id_uses_rn  (id_uses_rn),
      .id_uses_rm  (id_uses_rm),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .stall       (stall)
   );

   always #5 clk = ~clk;

   // Scoreboard: compare registered selects just after each edge.
   always @(posedge clk) begin
      if (exp_q.size() > 0) begin
         #1;
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         tests_run++;
         if ({fwd_a, fwd_b} !== mon_exp) begin
            tests_failed++;
            $display("FAIL %s: fwd_a/fwd_b got %b/%b expected %b/%b",
                     mon_name, fwd_a, fwd_b, mon_exp[3:2], mon_exp[1:0]);
         end
      end
   end

   function automatic instr_t nop();
      return '0;
   endfunction

   function automatic instr_t alu(input logic [4:0] rd, rn, rm);
      return '{valid:1'b1, rn:rn, rm:rm, uses_rn:1'b1, uses_rm:1'b1,
               rd:rd, regwrite:1'b1, memread:1'b0};
   endfunction

   function automatic instr_t ldur(input logic [4:0] rd, rn);
      return '{valid:1'b1, rn:rn, rm:5'd0, uses_rn:1'b1, uses_rm:1'b0,
               rd:rd, regwrite:1'b1, memread:1'b1};
   endfunction

   task automatic drive_id(input instr_t i, input logic fl);
      id_valid    = i.valid;
      id_rn       = i.rn;
      id_rm       = i.rm;
      id_uses_rn  = i.uses_rn;
      id_uses_rm  = i.uses_rm;
      id_rd       = i.rd;
      id_regwrite = i.regwrite;
      id_memread  = i.memread;
      flush       = fl;
   endtask

   // Present one ID instruction and queue the selects it must produce.
   task automatic issue(input instr_t i, input logic fl,
                        input logic [1:0] a, input logic [1:0] b, input string name);
      @(negedge clk);
      drive_id(i, fl);
      exp_q.push_back({a, b});
      name_q.push_back(name);
   endtask

   task automatic drain();
      issue(nop(), 1'b0, S_REG, S_REG, "drain0");
      issue(nop(), 1'b0, S_REG, S_REG, "drain1");
   endtask

   task automatic test_reset();
      instr_t r;
      rst_n = 1'b0;
      drive_id(nop(), 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         r = instr_t'($urandom);
         drive_id(r, 1'($urandom));
         #1;
         tests_run++;
         if (stall !== 1'b0 || fwd_a !== S_REG || fwd_b !== S_REG) begin
            tests_failed++;
            $display("FAIL reset_hold: stall/fwd_a/fwd_b got %b/%b/%b expected 0/00/00",
                     stall, fwd_a, fwd_b);
         end
      end
      @(negedge clk);
      drive_id(nop(), 1'b0);
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b0 || fwd_a !== S_REG || fwd_b !== S_REG) begin
         tests_failed++;
         $display("FAIL reset_release: stall/fwd_a/fwd_b got %b/%b/%b expected 0/00/00",
                  stall, fwd_a, fwd_b);
      end
   endtask

   task automatic test_ex_forward();
      drain();
      issue(alu(5'd1, 5'd5, 5'd6), 1'b0, S_REG, S_REG, "ex_add_x1");
      issue(alu(5'd7, 5'd1, 5'd2), 1'b0, S_MEM, S_REG, "ex_sub_uses_x1");
   endtask

   task automatic test_mem_forward();
      drain();
      issue(alu(5'd3, 5'd8, 5'd9),   1'b0, S_REG, S_REG, "mem_add_x3");
      issue(nop(),                   1'b0, S_REG, S_REG, "mem_gap");
      issue(alu(5'd11, 5'd3, 5'd10), 1'b0, S_WB,  S_REG, "mem_consumer");
      // Two producers of X3 in flight: the younger one in EX wins.
      issue(alu(5'd3, 5'd12, 5'd13), 1'b0, S_REG, S_REG, "prio_add1");
      issue(alu(5'd3, 5'd14, 5'd15), 1'b0, S_REG, S_REG, "prio_add2");
      issue(alu(5'd16, 5'd3, 5'd3),  1'b0, S_MEM, S_MEM, "prio_consumer");
   endtask

   task automatic test_load_use();
      instr_t c;
      drain();
      c = alu(5'd22, 5'd21, 5'd4);
      issue(ldur(5'd4, 5'd20), 1'b0, S_REG, S_REG, "lu_ldur");
      issue(c, 1'b0, S_REG, S_REG, "lu_stall_cycle");
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL lu_stall: stall got %b expected 1", stall);
      end
      issue(c, 1'b0, S_REG, S_WB, "lu_replay");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL lu_release: stall got %b expected 0", stall);
      end
      // Back-to-back loads to the same rd: still only one stall cycle.
      drain();
      issue(ldur(5'd4, 5'd20), 1'b0, S_REG, S_REG, "lu2_ldur1");
      issue(ldur(5'd4, 5'd23), 1'b0, S_REG, S_REG, "lu2_ldur2");
      issue(c, 1'b0, S_REG, S_REG, "lu2_stall_cycle");
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL lu2_stall: stall got %b expected 1", stall);
      end
      issue(c, 1'b0, S_REG, S_WB, "lu2_replay");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL lu2_release: stall got %b expected 0", stall);
      end
      // Matching rm that is not actually read must not stall.
      drain();
      c.uses_rm = 1'b0;
      issue(ldur(5'd4, 5'd20), 1'b0, S_REG, S_REG, "lu3_ldur");
      issue(c, 1'b0, S_REG, S_REG, "lu3_unused_rm");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL lu3_no_stall: stall got %b expected 0", stall);
      end
   endtask

   task automatic test_xzr();
      drain();
      issue(ldur(5'd31, 5'd1), 1'b0, S_REG, S_REG, "xzr_producer");
      issue(alu(5'd2, 5'd31, 5'd31), 1'b0, S_REG, S_REG, "xzr_consumer_ex");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL xzr_stall: stall got %b expected 0", stall);
      end
      issue(alu(5'd3, 5'd31, 5'd2), 1'b0, S_REG, S_MEM, "xzr_consumer_mem");
   endtask

   task automatic test_flush();
      drain();
      issue(ldur(5'd5, 5'd26), 1'b0, S_REG, S_REG, "fl_ldur");
      issue(alu(5'd8, 5'd5, 5'd9), 1'b1, S_REG, S_REG, "fl_flushed_consumer");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL fl_stall: stall got %b expected 0", stall);
      end
      issue(alu(5'd10, 5'd5, 5'd5), 1'b0, S_REG, S_REG, "fl_after");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL fl_after_stall: stall got %b expected 0", stall);
      end
      // Flush also suppresses an EX-stage forward.
      issue(alu(5'd6, 5'd0, 5'd0),  1'b0, S_REG, S_REG, "fl_add_x6");
      issue(alu(5'd7, 5'd6, 5'd6),  1'b1, S_REG, S_REG, "fl_kill_ex_fwd");
   endtask

   task automatic test_id_invalid();
      instr_t b;
      drain();
      b = alu(5'd9, 5'd7, 5'd7);
      b.valid = 1'b0;
      issue(ldur(5'd7, 5'd1), 1'b0, S_REG, S_REG, "inv_ldur");
      issue(b, 1'b0, S_REG, S_REG, "inv_bubble");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL inv_stall: stall got %b expected 0", stall);
      end
      issue(alu(5'd9, 5'd7, 5'd1), 1'b0, S_WB, S_REG, "inv_then_consumer");
   endtask

   task automatic test_reset_midstream();
      drain();
      issue(alu(5'd1, 5'd2, 5'd3), 1'b0, S_REG, S_REG, "mid_add_x1");
      issue(ldur(5'd4, 5'd1),      1'b0, S_MEM, S_REG, "mid_ldur_fwd");
      @(negedge clk);
      drive_id(alu(5'd22, 5'd21, 5'd4), 1'b0);
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_pre_stall: stall got %b expected 1", stall);
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (stall !== 1'b0 || fwd_a !== S_REG || fwd_b !== S_REG) begin
         tests_failed++;
         $display("FAIL mid_async_clear: stall/fwd_a/fwd_b got %b/%b/%b expected 0/00/00",
                  stall, fwd_a, fwd_b);
      end
      @(negedge clk);
      drive_id(nop(), 1'b0);
      rst_n = 1'b1;
      issue(alu(5'd5, 5'd1, 5'd4), 1'b0, S_REG, S_REG, "mid_first_after_reset");
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_after_stall: stall got %b expected 0", stall);
      end
   endtask

   initial begin
      test_reset();
      test_ex_forward();
      test_mem_forward();
      test_load_use();
      test_xzr();
      test_flush();
      test_id_invalid();
      test_reset_midstream();
      drain();
      @(negedge clk);
      drive_id(nop(), 1'b0);
      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Sequential forwarding and hazard controller for the 5-stage LEGv8 pipeline.
- Drives the 2-bit control inputs of the two EX-stage operand mux4 instances.
- Tracks destination-register metadata for the EX, MEM and WB stages internally.
- Registers the forward selects so they are valid throughout the EX cycle; detects load-use hazards and inserts bubbles.

Parameters:
- REG_BITS, 5, width of a register address.
- ZERO_REG, 31, address of XZR; never forwarded and never stalls.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rn  input  REG_BITS  first source register of the ID instruction.
- id_rm  input  REG_BITS  second source register of the ID instruction.
- id_uses_rn  input  1  ID instruction reads rn.
- id_uses_rm  input  1  ID instruction reads rm.
- id_rd  input  REG_BITS  destination register of the ID instruction.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- flush  input  1  taken branch resolved; kill the ID and EX instructions.
- fwd_a  output  2  control for the operand-A mux4.
- fwd_b  output  2  control for the operand-B mux4.
- stall  output  1  hold PC and IF/ID; combinational.

Behaviour:
- Reset: rst_n low asynchronously clears fwd_a, fwd_b, the stage valid bits and all tracked metadata to 0. stall reads 0 while reset is asserted.
- Select codes:
  - 00: register-file value.
  - 01: MEM/WB writeback data (ALU result or load data).
  - 10: EX/MEM ALU result.
  - 11: never driven.
- Internal stage records (EX, MEM, WB): each holds {valid, rd, regwrite, memread}. The record advances one stage per clock.
- Register-file bypass: the register file bypasses same-cycle writes internally, so the WB record is used for no forwarding decision.
- "Live" condition: a stage X is live for register r when valid_X=1, regwrite_X=1, rd_X==r and rd_X!=ZERO_REG.
- load_use: id_valid and EX is live for a register that the ID instruction uses (rn with id_uses_rn, or rm with id_uses_rm) and memread_EX=1.
- stall = load_use and not flush.
- Each rising edge, normal advance (no stall, no flush):
  - EX record <= ID inputs, with valid = id_valid.
  - MEM <= EX; WB <= MEM.
  - fwd_a <= 10 if EX is live for id_rn with id_uses_rn; else 01 if MEM is live for id_rn with id_uses_rn; else 00. fwd_b is computed the same way using id_rm and id_uses_rm.
  - EX-stage match has priority over MEM-stage match (newest producer wins).
- Each rising edge, stall:
  - EX record <= bubble (valid=0). MEM <= EX; WB <= MEM.
  - fwd_a and fwd_b <= 00.
  - Next cycle the load sits in MEM, so the held ID instruction gets code 01.
- Each rising edge, flush:
  - EX <= bubble and MEM <= bubble (the old EX instruction is killed). WB <= MEM.
  - fwd_a and fwd_b <= 00.
  - flush overrides a simultaneous load_use.
- Latency: the selects presented during cycle n+1 are those computed from the ID inputs at edge n+1.
- Two consecutive loads to the same rd followed by a consumer give exactly one stall cycle.
- id_valid=0: stall=0. A bubble enters EX and both selects become 00.
- Reset mid-operation: all in-flight records are discarded. The first post-reset instruction sees no forwarding.

Decomposition:
- Add to constants.vh: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, ZERO_REG=31, REG_BITS=5.
- One sub-module, fwd_stage_reg: holds one {valid, rd, regwrite, memread} record with async active-low reset and a synchronous bubble input. Instantiated three times for EX, MEM and WB.
- Select and stall logic stays in forward_ctrl.

Test Plan:
- Reset: hold rst_n=0 with random inputs; release -> fwd_a=fwd_b=00 and stall=0. Assert rst_n=0 mid-stream -> outputs clear immediately, with no clock edge needed.
- EX forward: issue ADD X1 (rd=1, regwrite) then SUB using rn=1, rm=2 -> for the SUB's EX cycle, fwd_a=10 and fwd_b=00.
- MEM forward and priority:
  - ADD X3, then a NOP, then a consumer with rn=3 -> fwd_a=01.
  - ADD X3, ADD X3, then a consumer with rn=3 -> fwd_a=10.
- Load-use: LDUR X4, then a consumer with rm=4 (id_uses_rm=1) -> stall=1 for one cycle with selects 00; the next cycle gives stall=0 and fwd_b=01.
- XZR: a producer with rd=31 (regwrite, memread), then a consumer with rn=31 -> stall=0 and fwd_a=00.
- Flush: LDUR X5 in EX, consumer with rn=5 in ID, flush=1 -> stall=0 and selects 00. A following instruction with rn=5 -> fwd_a=00, since MEM was bubbled.
